// File: rtl/eater_control_sequencer.sv
`default_nettype none
// ============================================================================
// eater_control_sequencer : T-step counter, halt latch and microcode decoder
//   for the SAP-style datapath. Optional macro: EATER_EARLY_FETCH_EN.
// Revision: 1.0
// ============================================================================
module eater_control_sequencer #(
    parameter int NUM_STEPS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step_en,
    input  logic [3:0]  opcode,
    input  logic        flag_c,
    input  logic        flag_z,
    output logic [15:0] ctrl,
    output logic [2:0]  t_step,
    output logic        halted,
    output logic        instr_done
);

    localparam logic [15:0] c_HLT = 16'h8000;
    localparam logic [15:0] c_MI  = 16'h4000;
    localparam logic [15:0] c_RI  = 16'h2000;
    localparam logic [15:0] c_RO  = 16'h1000;
    localparam logic [15:0] c_IO  = 16'h0800;
    localparam logic [15:0] c_II  = 16'h0400;
    localparam logic [15:0] c_AI  = 16'h0200;
    localparam logic [15:0] c_AO  = 16'h0100;
    localparam logic [15:0] c_EO  = 16'h0080;
    localparam logic [15:0] c_SU  = 16'h0040;
    localparam logic [15:0] c_BI  = 16'h0020;
    localparam logic [15:0] c_OI  = 16'h0010;
    localparam logic [15:0] c_CE  = 16'h0008;
    localparam logic [15:0] c_CO  = 16'h0004;
    localparam logic [15:0] c_J   = 16'h0002;
    localparam logic [15:0] c_FI  = 16'h0001;

    localparam logic [3:0] c_OP_LDA = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_SUB = 4'b0011;
    localparam logic [3:0] c_OP_STA = 4'b0100;
    localparam logic [3:0] c_OP_LDI = 4'b0101;
    localparam logic [3:0] c_OP_JMP = 4'b0110;
    localparam logic [3:0] c_OP_JC  = 4'b0111;
    localparam logic [3:0] c_OP_JZ  = 4'b1000;
    localparam logic [3:0] c_OP_OUT = 4'b1110;
    localparam logic [3:0] c_OP_HLT = 4'b1111;

    localparam logic [2:0] c_LAST_STEP = 3'(NUM_STEPS - 1);
    localparam logic [2:0] c_HALT_STEP = 3'd2;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_t_step;
    logic [2:0]  w_t_step_nxt;
    logic [2:0]  w_step_inc;
    logic        r_instr_done;
    logic        w_instr_done_nxt;
    logic [15:0] w_ucode_cur;
    logic        w_wrap;

    // Microcode ROM; undecoded opcodes and unlisted steps yield an empty word.
    function automatic logic [15:0] f_ucode(
        input logic [2:0] step,
        input logic [3:0] op,
        input logic       fc,
        input logic       fz
    );
        logic [15:0] word;
        word = 16'h0000;
        case (step)
            3'd0: word = c_CO | c_MI;
            3'd1: word = c_RO | c_II | c_CE;
            3'd2: begin
                case (op)
                    c_OP_LDA, c_OP_ADD, c_OP_SUB, c_OP_STA: word = c_IO | c_MI;
                    c_OP_LDI: word = c_IO | c_AI;
                    c_OP_JMP: word = c_IO | c_J;
                    c_OP_JC:  word = fc ? (c_IO | c_J) : 16'h0000;
                    c_OP_JZ:  word = fz ? (c_IO | c_J) : 16'h0000;
                    c_OP_OUT: word = c_AO | c_OI;
                    c_OP_HLT: word = c_HLT;
                    default:  word = 16'h0000;
                endcase
            end
            3'd3: begin
                case (op)
                    c_OP_LDA:           word = c_RO | c_AI;
                    c_OP_ADD, c_OP_SUB: word = c_RO | c_BI;
                    c_OP_STA:           word = c_AO | c_RI;
                    default:            word = 16'h0000;
                endcase
            end
            3'd4: begin
                case (op)
                    c_OP_ADD: word = c_EO | c_AI | c_FI;
                    c_OP_SUB: word = c_EO | c_AI | c_SU | c_FI;
                    default:  word = 16'h0000;
                endcase
            end
            default: word = 16'h0000;
        endcase
        return word;
    endfunction

    assign w_step_inc  = r_t_step + 3'd1;
    assign w_ucode_cur = f_ucode(r_t_step, opcode, flag_c, flag_z);

`ifdef EATER_EARLY_FETCH_EN
    logic [15:0] w_ucode_next;

    // An empty next word means the instruction has nothing left to do: fetch now.
    assign w_ucode_next = f_ucode(w_step_inc, opcode, flag_c, flag_z);
    assign w_wrap       = (r_t_step == c_LAST_STEP) ||
                          ((r_t_step >= 3'd2) && (w_ucode_next == 16'h0000));
`else
    assign w_wrap       = (r_t_step == c_LAST_STEP);
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_t_step_nxt     = r_t_step;
        w_instr_done_nxt = 1'b0;
        ctrl             = c_HLT;
        case (r_state)
            ST_RUN: begin
                ctrl = w_ucode_cur;
                if (step_en) begin
                    if ((r_t_step == c_HALT_STEP) && (opcode == c_OP_HLT)) begin
                        w_state_nxt = ST_HALT;
                    end else if (w_wrap) begin
                        w_t_step_nxt     = 3'd0;
                        w_instr_done_nxt = 1'b1;
                    end else begin
                        w_t_step_nxt = w_step_inc;
                    end
                end
            end
            ST_HALT: begin
                ctrl = c_HLT;
            end
            default: begin
                ctrl = c_HLT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_t_step     <= 3'd0;
            r_instr_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_t_step     <= w_t_step_nxt;
            r_instr_done <= w_instr_done_nxt;
        end
    end

    assign t_step     = r_t_step;
    assign halted     = (r_state == ST_HALT);
    assign instr_done = r_instr_done;

endmodule
`default_nettype wire

// File: tb/tb_eater_control_sequencer.sv
`default_nettype none
// ============================================================================
// tb_eater_control_sequencer : directed scoreboard bench for the sequencer.
// Revision: 1.0
// ============================================================================
module tb_eater_control_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        step_en;
    logic [3:0]  opcode;
    logic        flag_c;
    logic        flag_z;
    logic [15:0] ctrl;
    logic [2:0]  t_step;
    logic        halted;
    logic        instr_done;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [15:0] c;
        logic [2:0]  t;
        logic        h;
        logic        d;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    eater_control_sequencer #(.NUM_STEPS(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_en    (step_en),
        .opcode     (opcode),
        .flag_c     (flag_c),
        .flag_z     (flag_z),
        .ctrl       (ctrl),
        .t_step     (t_step),
        .halted     (halted),
        .instr_done (instr_done)
    );

    task automatic push(input string tag, input logic [15:0] c, input logic [2:0] t,
                        input logic h, input logic d);
        exp_t e;
        e.tag = tag; e.c = c; e.t = t; e.h = h; e.d = d;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        n_assert++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty: got %0d entries, required at least 1", sb.size());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_assert++;
            assert (ctrl === e.c) else begin
                n_fail++;
                $error("FAIL %s.ctrl: got %h, required %h", e.tag, ctrl, e.c);
            end
            n_assert++;
            assert (t_step === e.t) else begin
                n_fail++;
                $error("FAIL %s.t_step: got %0d, required %0d", e.tag, t_step, e.t);
            end
            n_assert++;
            assert (halted === e.h) else begin
                n_fail++;
                $error("FAIL %s.halted: got %b, required %b", e.tag, halted, e.h);
            end
            n_assert++;
            assert (instr_done === e.d) else begin
                n_fail++;
                $error("FAIL %s.instr_done: got %b, required %b", e.tag, instr_done, e.d);
            end
        end
    endtask

    // Drive step_en, record what the next edge should produce, then sample at the falling edge.
    task automatic edge_exp(input logic en, input string tag, input logic [15:0] c,
                            input logic [2:0] t, input logic h, input logic d);
        step_en = en;
        push(tag, c, t, h, d);
        @(posedge clk);
        @(negedge clk);
        check_out();
    endtask

    task automatic now_exp(input string tag, input logic [15:0] c, input logic [2:0] t,
                           input logic h, input logic d);
        push(tag, c, t, h, d);
        #1;
        check_out();
    endtask

    task automatic do_reset(input logic [3:0] op);
        @(negedge clk);
        rst_n  = 1'b0;
        opcode = op;
        flag_c = 1'b0;
        flag_z = 1'b0;
        now_exp("reset", 16'h4004, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        step_en = 1'b0;
        opcode  = 4'b0010;
        flag_c  = 1'b0;
        flag_z  = 1'b0;
        #2;
        now_exp("por", 16'h4004, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD: full five-step instruction, wrap and single instr_done pulse
        now_exp("add_t0", 16'h4004, 3'd0, 1'b0, 1'b0);
        edge_exp(1'b1, "add_t1", 16'h1408, 3'd1, 1'b0, 1'b0);
        edge_exp(1'b1, "add_t2", 16'h4800, 3'd2, 1'b0, 1'b0);
        edge_exp(1'b1, "add_t3", 16'h1020, 3'd3, 1'b0, 1'b0);
        edge_exp(1'b1, "add_t4", 16'h0281, 3'd4, 1'b0, 1'b0);
        edge_exp(1'b1, "add_wrap", 16'h4004, 3'd0, 1'b0, 1'b1);
        edge_exp(1'b1, "add_next_t1", 16'h1408, 3'd1, 1'b0, 1'b0);

        // JC taken / not taken, flag sampled live
        do_reset(4'b0111);
        flag_c = 1'b1;
        edge_exp(1'b1, "jc_t1", 16'h1408, 3'd1, 1'b0, 1'b0);
        edge_exp(1'b1, "jc_taken", 16'h0802, 3'd2, 1'b0, 1'b0);
        flag_c = 1'b0;
        now_exp("jc_not_taken", 16'h0000, 3'd2, 1'b0, 1'b0);

        // JZ taken / not taken
        do_reset(4'b1000);
        flag_z = 1'b1;
        edge_exp(1'b1, "jz_t1", 16'h1408, 3'd1, 1'b0, 1'b0);
        edge_exp(1'b1, "jz_taken", 16'h0802, 3'd2, 1'b0, 1'b0);
        flag_z = 1'b0;
        now_exp("jz_not_taken", 16'h0000, 3'd2, 1'b0, 1'b0);

        // OUT
        do_reset(4'b1110);
        edge_exp(1'b1, "out_t1", 16'h1408, 3'd1, 1'b0, 1'b0);
        edge_exp(1'b1, "out_t2", 16'h0110, 3'd2, 1'b0, 1'b0);

        // HLT: latch, freeze against step_en and opcode changes, reset clears
        do_reset(4'b1111);
        edge_exp(1'b1, "hlt_t1", 16'h1408, 3'd1, 1'b0, 1'b0);
        edge_exp(1'b1, "hlt_t2", 16'h8000, 3'd2, 1'b0, 1'b0);
        edge_exp(1'b1, "hlt_latch", 16'h8000, 3'd2, 1'b1, 1'b0);
        opcode = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            edge_exp(1'b1, "hlt_frozen", 16'h8000, 3'd2, 1'b1, 1'b0);
        end
        do_reset(4'b0010);
        now_exp("hlt_cleared", 16'h4004, 3'd0, 1'b0, 1'b0);

        // STA: step_en low holds everything at T3
        do_reset(4'b0100);
        edge_exp(1'b1, "sta_t1", 16'h1408, 3'd1, 1'b0, 1'b0);
        edge_exp(1'b1, "sta_t2", 16'h4800, 3'd2, 1'b0, 1'b0);
        edge_exp(1'b1, "sta_t3", 16'h2100, 3'd3, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            edge_exp(1'b0, "sta_hold", 16'h2100, 3'd3, 1'b0, 1'b0);
        end
`ifdef EATER_EARLY_FETCH_EN
        edge_exp(1'b1, "sta_early_wrap", 16'h4004, 3'd0, 1'b0, 1'b1);
`else
        edge_exp(1'b1, "sta_t4", 16'h0000, 3'd4, 1'b0, 1'b0);
        edge_exp(1'b1, "sta_wrap", 16'h4004, 3'd0, 1'b0, 1'b1);
`endif

        // LDI: three steps with early fetch, five otherwise
        do_reset(4'b0101);
        edge_exp(1'b1, "ldi_t1", 16'h1408, 3'd1, 1'b0, 1'b0);
        edge_exp(1'b1, "ldi_t2", 16'h0A00, 3'd2, 1'b0, 1'b0);
`ifdef EATER_EARLY_FETCH_EN
        edge_exp(1'b1, "ldi_early_wrap", 16'h4004, 3'd0, 1'b0, 1'b1);
`else
        edge_exp(1'b1, "ldi_t3", 16'h0000, 3'd3, 1'b0, 1'b0);
        edge_exp(1'b1, "ldi_t4", 16'h0000, 3'd4, 1'b0, 1'b0);
        edge_exp(1'b1, "ldi_wrap", 16'h4004, 3'd0, 1'b0, 1'b1);
`endif
        edge_exp(1'b1, "ldi_next_t1", 16'h1408, 3'd1, 1'b0, 1'b0);

        // Undecoded opcode behaves as NOP
        do_reset(4'b1010);
        edge_exp(1'b1, "nop_t1", 16'h1408, 3'd1, 1'b0, 1'b0);
        edge_exp(1'b1, "nop_t2", 16'h0000, 3'd2, 1'b0, 1'b0);
`ifdef EATER_EARLY_FETCH_EN
        edge_exp(1'b1, "nop_early_wrap", 16'h4004, 3'd0, 1'b0, 1'b1);
`else
        edge_exp(1'b1, "nop_t3", 16'h0000, 3'd3, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eater_control_sequencer.md
Name: eater_control_sequencer

Overview:
- Microcode control unit for the tt_um_eater_8bit SAP-style datapath (PC, MAR, RAM, IR, A, B, ALU, OUT, flags).
- Holds the T-step counter and the halt latch.
- Decodes the IR opcode nibble and the live C/Z flags into the 16-bit control word that sequences every bus transfer.
- Sits between the clock-enable/single-step logic and the datapath registers.

Parameters:
- NUM_STEPS, 5, micro-steps per instruction (legal range 3..8); the step counter wraps from NUM_STEPS-1 to 0.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- step_en  input  1  clock enable from run/single-step logic; the counter advances only when this is 1
- opcode  input  4  IR[7:4], stable from T2 onward
- flag_c  input  1  registered carry flag
- flag_z  input  1  registered zero flag
- ctrl  output  16  control word; bit order 15..0 = HLT MI RI RO IO II AI AO EO SU BI OI CE CO J FI
- t_step  output  3  current micro-step
- halted  output  1  halt latch
- instr_done  output  1  one-cycle pulse when the counter wraps to 0 (instruction retired)

Behaviour:
- Reset (async, rst_n=0): t_step=0, halted=0, instr_done=0. ctrl then shows the T0 word (CO|MI).
- ctrl is combinational from t_step, opcode, flag_c, flag_z and halted. There is no extra latency: the control word is valid in the same cycle as the step.
- Counter, on a rising edge with step_en=1 and halted=0:
  - t_step = (t_step==NUM_STEPS-1) ? 0 : t_step+1
  - instr_done=1 for the cycle after a wrap edge, 0 otherwise
  - With step_en=0 all state holds and instr_done=0.
- Fetch, for every opcode:
  - T0 = CO|MI
  - T1 = RO|II|CE
- Execute (T2/T3/T4; any unlisted step = 0):
  - 0000 NOP: none
  - 0001 LDA: IO|MI / RO|AI / 0
  - 0010 ADD: IO|MI / RO|BI / EO|AI|FI
  - 0011 SUB: IO|MI / RO|BI / EO|AI|SU|FI
  - 0100 STA: IO|MI / AO|RI / 0
  - 0101 LDI: IO|AI
  - 0110 JMP: IO|J
  - 0111 JC: IO|J if flag_c=1, else 0
  - 1000 JZ: IO|J if flag_z=1, else 0
  - 1110 OUT: AO|OI
  - 1111 HLT: HLT
  - 1001–1101: treated as NOP
- Halt:
  - At T2 with opcode=1111 and step_en=1, the next edge sets halted=1 and t_step holds at 2.
  - While halted: ctrl = HLT only; counter frozen; instr_done=0; step_en is ignored.
  - Only rst_n clears the halt.
- Flags are sampled live. A flag change in the same cycle as a JC/JZ step affects ctrl combinationally; the flag register is responsible for its stability.
- Steps ≥ NUM_STEPS never occur. If NUM_STEPS=3, T3/T4 microcode is unreachable; this is legal for a reduced instruction set.
- Reset mid-instruction aborts it immediately. The next instruction starts with a fetch at T0.
- Bus exclusivity: at most one of CO, RO, IO, AO, EO is set in any ctrl value (guaranteed by the microcode table).

Optional Feature:
- Macro: EATER_EARLY_FETCH_EN.
- Defined:
  - If the microcode word for step t_step+1 is 0 (and t_step ≥ 2), the counter wraps to 0 on the next enabled edge instead of incrementing. instr_done pulses accordingly.
  - JC/JZ not taken ends after T2. Example: LDI takes 3 cycles instead of 5.
  - NOP ends after T1's following step, i.e. T2 is the last step.
- Undefined: fixed NUM_STEPS cycles per instruction, as above.

Test Plan:
- Reset then step_en=1: T0 ctrl=16'h4004 (CO|MI); T1 ctrl=16'h1408 (RO|II|CE); t_step wraps to 0 after 5 enabled edges; instr_done pulses once.
- opcode=0010 (ADD): T2=16'h4800, T3=16'h1020, T4=16'h0281.
- opcode=0111 with flag_c=1: T2=16'h0802; repeat with flag_c=0: T2=16'h0000. Same check for opcode=1000 with flag_z.
- opcode=1111: T2 ctrl=16'h8000; after the next edge halted=1; 10 further edges with step_en=1 leave t_step=2 and ctrl=16'h8000; rst_n pulse gives t_step=0, halted=0.
- step_en held 0 for 7 edges at T3 of STA: t_step stays 3, ctrl stays 16'h2100, no instr_done.
- With EATER_EARLY_FETCH_EN, opcode=0101 (LDI): sequence T0,T1,T2,T0; instr_done pulses after 3 enabled edges.
